// File: rtl/cache_def.sv
`default_nettype none
// ============================================================================
//  Package   : cache_def
//  Purpose   : Shared cache/memory interface types plus the constants and
//              state encoding of the cache-to-memory bridge.
//  Revision  : 1.0 - initial release
// ============================================================================
package cache_def;

   // Line and backing-bus geometry; BEATS is always derived, never set.
   localparam int LINE_W = 128;
   localparam int BUS_W  = 32;
   localparam int BEATS  = LINE_W / BUS_W;

   // Line request from the L1 data cache (rw: 1 = write-back, 0 = refill).
   typedef struct packed {
      logic [31:0]       addr;
      logic [LINE_W-1:0] data;
      logic              rw;
      logic              valid;
   } mem_req_type;

   // Line response to the L1 data cache.
   typedef struct packed {
      logic [LINE_W-1:0] data;
      logic              ready;
   } mem_data_type;

   // Bridge control states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } bridge_state_e;

endpackage
`default_nettype wire

// File: rtl/line_assembler.sv
`default_nettype none
// ============================================================================
//  Module    : line_assembler
//  Purpose   : Collects returned read words, in arrival order, into one
//              line. Flags the word that completes the line (o_last) and
//              holds a done flag until cleared for the next refill.
//  Revision  : 1.0 - initial release
// ============================================================================
module line_assembler
   import cache_def::*;
#(
   parameter int WORD_W  = BUS_W,
   parameter int N_WORDS = BEATS
)(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      i_clr,
   input  logic                      i_en,
   input  logic [WORD_W-1:0]         i_word,
   output logic [WORD_W*N_WORDS-1:0] o_line,
   output logic                      o_last,
   output logic                      o_done
);

   localparam int                 c_IDX_W = $clog2(N_WORDS);
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(N_WORDS - 1);

   logic [c_IDX_W-1:0] r_cnt;
   logic               r_done;
   logic               w_take;

   // Words arriving after the line is complete are not stored.
   assign w_take = i_en & ~r_done;
   assign o_last = w_take & (r_cnt == c_LAST);
   assign o_done = r_done;

   // Return counter and completion flag, restarted for each new refill.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else if (w_take) begin
         r_cnt <= r_cnt + 1'b1;
         if (o_last) begin
            r_done <= 1'b1;
         end
      end
   end

   generate
      for (genvar g = 0; g < N_WORDS; g++) begin : g_word
         logic [WORD_W-1:0] r_word;

         // Word slot g takes the g-th returned word of the line.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               r_word <= '0;
            end else if (w_take && (r_cnt == c_IDX_W'(g))) begin
               r_word <= i_word;
            end
         end

         assign o_line[g*WORD_W +: WORD_W] = r_word;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/dcache_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module    : dcache_mem_bridge
//  Purpose   : Turns one line-wide cache memory request into a burst of
//              word beats on the backing bus, assembles refills into a
//              line, answers with a one-cycle ready pulse and counts
//              completed line reads and writes.
//  Revision  : 1.0 - initial release
// ============================================================================
module dcache_mem_bridge
   import cache_def::*;
(
   input  logic         clk_i,
   input  logic         rst_ni,
   input  mem_req_type  mem_req_i,
   output mem_data_type mem_data_o,
   output logic         bus_req_o,
   output logic         bus_we_o,
   output logic [31:0]  bus_addr_o,
   output logic [31:0]  bus_wdata_o,
   input  logic         bus_gnt_i,
   input  logic         bus_rvalid_i,
   input  logic [31:0]  bus_rdata_i,
   output logic [31:0]  no_rd_o,
   output logic [31:0]  no_wr_o
);

   localparam int                 c_IDX_W  = $clog2(BEATS);
   localparam int                 c_OFF_W  = $clog2(LINE_W / 8);
   localparam int                 c_WOFF_W = $clog2(BUS_W / 8);
   localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(BEATS - 1);

   bridge_state_e      r_state;
   bridge_state_e      w_next;
   logic [31:c_OFF_W]  r_line_addr;
   logic [LINE_W-1:0]  r_wline;
   logic [LINE_W-1:0]  r_rline;
   logic               r_rw;
   logic               r_armed;
   logic [c_IDX_W-1:0] r_issue;
   logic               r_all_issued;
   logic [31:0]        r_no_rd;
   logic [31:0]        r_no_wr;

   logic               w_capture;
   logic               w_beat;
   logic               w_rd_en;
   logic               w_rd_last;
   logic               w_asm_done;
   logic [LINE_W-1:0]  w_asm_line;
   logic               w_unused;

   // Line offset bits of the request address are never used.
   assign w_unused  = ^mem_req_i.addr[c_OFF_W-1:0];

   // A request is taken only from IDLE, and only once per valid assertion.
   assign w_capture = (r_state == IDLE) & mem_req_i.valid & r_armed;
   assign w_beat    = bus_req_o & bus_gnt_i;
   assign w_rd_en   = bus_rvalid_i & (r_state == RD) & ~w_asm_done;

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and bus handshake outputs.
   always_comb begin
      w_next    = r_state;
      bus_req_o = 1'b0;
      bus_we_o  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_capture) begin
               w_next = mem_req_i.rw ? WR : RD;
            end
         end
         WR: begin
            bus_req_o = 1'b1;
            bus_we_o  = 1'b1;
            if (bus_gnt_i && (r_issue == c_LAST)) begin
               w_next = RESP;
            end
         end
         RD: begin
            // Stop requesting once all beats are out; returns may lag.
            bus_req_o = ~r_all_issued;
            if (w_rd_last) begin
               w_next = RESP;
            end
         end
         RESP: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Request capture and beat issue counter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_line_addr  <= '0;
         r_wline      <= '0;
         r_rw         <= 1'b0;
         r_issue      <= '0;
         r_all_issued <= 1'b0;
      end else if (w_capture) begin
         r_line_addr  <= mem_req_i.addr[31:c_OFF_W];
         r_wline      <= mem_req_i.data;
         r_rw         <= mem_req_i.rw;
         r_issue      <= '0;
         r_all_issued <= 1'b0;
      end else if (w_beat) begin
         r_issue <= r_issue + 1'b1;
         if (r_issue == c_LAST) begin
            r_all_issued <= 1'b1;
         end
      end
   end

   // Beat address stays inside the line; only the word index moves.
   assign bus_addr_o = {r_line_addr, r_issue, {c_WOFF_W{1'b0}}};

   // Write word for the current beat.
   always_comb begin
      bus_wdata_o = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (r_issue == c_IDX_W'(k)) begin
            bus_wdata_o = r_wline[k*BUS_W +: BUS_W];
         end
      end
   end

   line_assembler #(
      .WORD_W  (BUS_W),
      .N_WORDS (BEATS)
   ) u_line_assembler (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_clr  (w_capture),
      .i_en   (w_rd_en),
      .i_word (bus_rdata_i),
      .o_line (w_asm_line),
      .o_last (w_rd_last),
      .o_done (w_asm_done)
   );

   // Response register, line statistics and re-trigger guard.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rline <= '0;
         r_no_rd <= '0;
         r_no_wr <= '0;
         r_armed <= 1'b1;
      end else begin
         if (r_state == RESP) begin
            if (r_rw) begin
               r_no_wr <= r_no_wr + 32'd1;
            end else begin
               r_no_rd <= r_no_rd + 32'd1;
               r_rline <= w_asm_line;
            end
         end
         if (!mem_req_i.valid) begin
            r_armed <= 1'b1;
         end else if (r_state == RESP) begin
            r_armed <= 1'b0;
         end
      end
   end

   // Response: fresh line during a read RESP, otherwise the last read line.
   always_comb begin
      mem_data_o.ready = (r_state == RESP);
      mem_data_o.data  = ((r_state == RESP) && !r_rw) ? w_asm_line : r_rline;
   end

   assign no_rd_o = r_no_rd;
   assign no_wr_o = r_no_wr;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module    : tb_dcache_mem_bridge
//  Purpose   : Self-checking bench for dcache_mem_bridge: directed cases plus
//              randomized requests and bus timing against a line-level model
//              of the expected beats, response data and counters.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_dcache_mem_bridge;
   import cache_def::*;

   logic         clk_i = 1'b0;
   logic         rst_ni;
   mem_req_type  mem_req_i;
   mem_data_type mem_data_o;
   logic         bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i;
   logic [31:0]  bus_addr_o, bus_wdata_o, bus_rdata_i, no_rd_o, no_wr_o;

   always #5 clk_i = ~clk_i;

   dcache_mem_bridge dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .mem_req_i    (mem_req_i),
      .mem_data_o   (mem_data_o),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i),
      .no_rd_o      (no_rd_o),
      .no_wr_o      (no_wr_o)
   );

   // ---------------- reference model state ----------------
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } beat_t;

   logic [31:0]  mem [logic [31:0]];
   beat_t        exp_beats [$];
   logic [31:0]  rv_data [$];
   int           rv_min [$];
   logic [127:0] exp_line, last_rd_line;
   logic [31:0]  exp_rd, exp_wr;
   bit           txn_open, ready_seen;
   int           cyc, start_cyc, ready_cyc, readies_total, burst_beats, last_rv_cyc;
   int           gnt_pct, rv_pct, rv_gap, stall_beat, stall_left;
   int           n_vec, n_err;

   task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Backing memory: written words read back, untouched words are a hash.
   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // One clock: observe outputs at negedge, then drive bus inputs.
   task automatic tick();
      logic        req, we, g;
      logic [31:0] a, wd;
      beat_t       b;
      @(negedge clk_i);
      cyc++;
      req = bus_req_o; we = bus_we_o; a = bus_addr_o; wd = bus_wdata_o;
      if (mem_data_o.ready) begin
         readies_total++;
         check_val("ready_expected", {127'd0, !txn_open}, 128'd0);
         if (txn_open) begin
            ready_seen = 1'b1;
            ready_cyc  = cyc;
            txn_open   = 1'b0;
            check_val("resp_data", mem_data_o.data, exp_line);
            check_val("beats_missing", exp_beats.size(), 0);
         end
      end
      g = ($urandom_range(0, 99) < gnt_pct);
      if (req && stall_left > 0 && burst_beats == stall_beat) begin
         g = 1'b0;
         stall_left--;
      end
      bus_gnt_i = g;
      if (req && g) begin
         check_val("beat_expected", {127'd0, exp_beats.size() == 0}, 128'd0);
         if (exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            burst_beats++;
            check_val("beat_addr", a, b.addr);
            check_val("beat_we", we, b.we);
            if (b.we) check_val("beat_wdata", wd, b.wdata);
            if (we) mem[a] = wd;
            else begin
               rv_data.push_back(rd_mem(a));
               rv_min.push_back(cyc + 1);
            end
         end
      end
      if (rv_data.size() > 0 && rv_min[0] <= cyc && cyc > last_rv_cyc + rv_gap &&
          $urandom_range(0, 99) < rv_pct) begin
         bus_rvalid_i = 1'b1;
         bus_rdata_i  = rv_data.pop_front();
         void'(rv_min.pop_front());
         last_rv_cyc  = cyc;
      end else begin
         bus_rvalid_i = 1'b0;
         bus_rdata_i  = $urandom;
      end
   endtask

   task automatic start_txn(input logic rw, input logic [31:0] addr, input logic [127:0] data);
      logic [31:0] base;
      beat_t       b;
      base = {addr[31:4], 4'h0};
      for (int k = 0; k < 4; k++) begin
         b.addr  = base + 32'(4 * k);
         b.we    = rw;
         b.wdata = data[32*k +: 32];
         exp_beats.push_back(b);
         if (!rw) exp_line[32*k +: 32] = rd_mem(b.addr);
      end
      if (rw) exp_line = last_rd_line;
      txn_open    = 1'b1;
      ready_seen  = 1'b0;
      burst_beats = 0;
      mem_req_i   = '{addr: addr, data: data, rw: rw, valid: 1'b1};
      start_cyc   = cyc;
   endtask

   task automatic run_txn(input logic rw, input logic [31:0] addr, input logic [127:0] data,
                          input int exp_lat, input int hold);
      start_txn(rw, addr, data);
      for (int i = 0; i < 300 && !ready_seen; i++) tick();
      check_val("ready_seen", {127'd0, ready_seen}, 128'd1);
      if (ready_seen) begin
         if (exp_lat > 0) check_val("latency", ready_cyc - start_cyc, exp_lat);
         if (rw) exp_wr = exp_wr + 32'd1;
         else begin
            exp_rd       = exp_rd + 32'd1;
            last_rd_line = exp_line;
         end
      end else begin
         txn_open = 1'b0;
         exp_beats.delete();
      end
      repeat (hold) tick();
      mem_req_i.valid = 1'b0;
      tick();
      check_val("no_rd", no_rd_o, exp_rd);
      check_val("no_wr", no_wr_o, exp_wr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int r0;
      n_vec = 0; n_err = 0; cyc = 0; readies_total = 0; last_rv_cyc = -100;
      gnt_pct = 100; rv_pct = 100; rv_gap = 0; stall_beat = -1; stall_left = 0;
      exp_rd = '0; exp_wr = '0; last_rd_line = '0; exp_line = '0; txn_open = 1'b0;
      mem_req_i = '0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      rst_ni = 1'b0;
      tick(); tick();
      check_val("rst_bus_req", bus_req_o, 0);
      check_val("rst_bus_addr", bus_addr_o, 0);
      check_val("rst_ready", mem_data_o.ready, 0);
      check_val("rst_data", mem_data_o.data, 0);
      check_val("rst_no_rd", no_rd_o, 0);
      rst_ni = 1'b1;
      tick();

      // Directed read, best-case timing.
      mem[32'h1230] = 32'h11; mem[32'h1234] = 32'h22;
      mem[32'h1238] = 32'h33; mem[32'h123C] = 32'h44;
      run_txn(1'b0, 32'h0000_1234, '0, 6, 0);
      check_val("rd1_line", last_rd_line, 128'h00000044_00000033_00000022_00000011);

      // Directed write; response data must stay the last read line.
      run_txn(1'b1, 32'h0000_2000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 5, 0);

      // Read with a 3-cycle grant stall on beat 1 and 2-cycle return gaps.
      stall_beat = 1; stall_left = 3; rv_gap = 2;
      r0 = readies_total;
      run_txn(1'b0, 32'h0000_4A50, '0, 0, 0);
      check_val("stall_ready_cnt", readies_total - r0, 1);
      stall_beat = -1; stall_left = 0; rv_gap = 0;

      // Valid held after ready must not start a second burst.
      r0 = readies_total;
      run_txn(1'b0, 32'h0000_5000, '0, 6, 3);
      run_txn(1'b1, 32'h0000_6000, {$urandom, $urandom, $urandom, $urandom}, 5, 0);
      check_val("held_valid_bursts", readies_total - r0, 2);

      // Reset during beat 2 of a write.
      start_txn(1'b1, 32'h0000_3000, {$urandom, $urandom, $urandom, $urandom});
      tick(); tick(); tick();
      rst_ni = 1'b0;
      mem_req_i.valid = 1'b0;
      txn_open = 1'b0;
      exp_beats.delete(); rv_data.delete(); rv_min.delete();
      exp_rd = '0; exp_wr = '0; last_rd_line = '0;
      tick();
      rst_ni = 1'b1;
      check_val("rr_bus_req", bus_req_o, 0);
      check_val("rr_bus_we", bus_we_o, 0);
      check_val("rr_bus_addr", bus_addr_o, 0);
      check_val("rr_bus_wdata", bus_wdata_o, 0);
      check_val("rr_data", mem_data_o.data, 0);
      check_val("rr_ready", mem_data_o.ready, 0);
      check_val("rr_no_rd", no_rd_o, 0);
      check_val("rr_no_wr", no_wr_o, 0);
      tick();
      run_txn(1'b0, 32'h0000_7770, '0, 6, 0);

      // Read counter wrap.
      force dut.r_no_rd = 32'hFFFF_FFFF;
      tick();
      release dut.r_no_rd;
      exp_rd = 32'hFFFF_FFFF;
      check_val("no_rd_preload", no_rd_o, exp_rd);
      run_txn(1'b0, 32'h0000_8000, '0, 6, 0);
      check_val("no_rd_wrapped", no_rd_o, 0);

      // Randomized requests and bus timing.
      for (int t = 0; t < 30; t++) begin
         gnt_pct = $urandom_range(30, 100);
         rv_pct  = $urandom_range(30, 100);
         run_txn(1'($urandom_range(0, 1)), $urandom,
                 {$urandom, $urandom, $urandom, $urandom}, 0, $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
